// File: rtl/spi_slave_param.sv
// rtl/spi_slave_param.sv - parametrised SPI slave with one-word TX holding register
module spi_slave_param #(
    parameter int DATA_W      = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SCK,
    input  logic              SIMO,
    input  logic              CS,
    output logic              SOMI,
    output logic              somi_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              tx_underrun,
    output logic              frame_err
);
    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic             CPOL_B   = (CPOL != 0);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t                 state;
    logic [SYNC_STAGES:0]   sck_sr;
    logic [SYNC_STAGES:0]   cs_sr;
    logic [SYNC_STAGES-1:0] simo_sr;
    logic [DATA_W-1:0]      tx_shift;
    logic [DATA_W-1:0]      rx_shift;
    logic [DATA_W-1:0]      hold;
    logic                   hold_full;
    logic                   somi_bit;
    logic [CNT_W-1:0]       bit_cnt;

    logic sck_cur, sck_prev, cs_cur, cs_prev, simo_cur;
    logic lead, trail, sample_edge, shift_edge, cs_fall, cs_rise;
    logic start_cs, in_frame, sample_now, wrap, word_start, shift_ok, tx_out_bit;
    logic [DATA_W-1:0] rx_next;
    logic [DATA_W-1:0] tx_shift_next;

    // Pin synchronisers; CS resets deasserted and SCK at its idle level so reset never fakes an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sr  <= {(SYNC_STAGES+1){CPOL_B}};
            cs_sr   <= '1;
            simo_sr <= '0;
        end else begin
            sck_sr  <= {sck_sr[SYNC_STAGES-1:0], SCK};
            cs_sr   <= {cs_sr[SYNC_STAGES-1:0], CS};
            simo_sr <= {simo_sr[SYNC_STAGES-2:0], SIMO};
        end
    end

    assign sck_cur  = sck_sr[SYNC_STAGES-1];
    assign sck_prev = sck_sr[SYNC_STAGES];
    assign cs_cur   = cs_sr[SYNC_STAGES-1];
    assign cs_prev  = cs_sr[SYNC_STAGES];
    assign simo_cur = simo_sr[SYNC_STAGES-1];

    // Leading edge leaves the idle level, trailing edge returns to it
    assign lead        = (sck_cur != CPOL_B) && (sck_prev == CPOL_B);
    assign trail       = (sck_cur == CPOL_B) && (sck_prev != CPOL_B);
    assign sample_edge = (CPHA != 0) ? trail : lead;
    assign shift_edge  = (CPHA != 0) ? lead : trail;
    assign cs_fall     = cs_prev && !cs_cur;
    assign cs_rise     = !cs_prev && cs_cur;

    assign start_cs   = (state == IDLE) && cs_fall;
    assign in_frame   = (state == ACTIVE) && !cs_rise;
    assign sample_now = in_frame && sample_edge;
    assign wrap       = (bit_cnt == CNT_LAST);
    assign word_start = start_cs || (sample_now && wrap);

    // With CPHA=0 the trailing edge after the last sample must not disturb the freshly loaded word
    assign shift_ok = (CPHA != 0) ? 1'b1 : (bit_cnt != '0);

    assign rx_next       = (MSB_FIRST != 0) ? {rx_shift[DATA_W-2:0], simo_cur}
                                            : {simo_cur, rx_shift[DATA_W-1:1]};
    assign tx_out_bit    = (MSB_FIRST != 0) ? tx_shift[DATA_W-1] : tx_shift[0];
    assign tx_shift_next = (MSB_FIRST != 0) ? {tx_shift[DATA_W-2:0], 1'b0}
                                            : {1'b0, tx_shift[DATA_W-1:1]};

    // Frame FSM, holding register handshake, TX/RX shifting and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tx_shift    <= '0;
            rx_shift    <= '0;
            hold        <= '0;
            hold_full   <= 1'b0;
            somi_bit    <= 1'b0;
            bit_cnt     <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;

            if (start_cs) begin
                state <= ACTIVE;
            end else if ((state == ACTIVE) && cs_rise) begin
                state <= IDLE;
            end

            // A full register is consumed at word start; an empty one may still accept tx_load then
            if (word_start && hold_full) begin
                hold_full <= 1'b0;
            end else if (tx_load && !hold_full) begin
                hold      <= tx_data;
                hold_full <= 1'b1;
            end

            if (word_start) begin
                tx_shift <= hold_full ? hold : '0;
                if (!hold_full) begin
                    tx_underrun <= 1'b1;
                end
            end else if (in_frame && shift_edge && shift_ok) begin
                tx_shift <= tx_shift_next;
                if (CPHA != 0) begin
                    somi_bit <= tx_out_bit;
                end
            end

            if (start_cs) begin
                bit_cnt <= '0;
            end else if ((state == ACTIVE) && cs_rise) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
                if (bit_cnt != '0) begin
                    frame_err <= 1'b1;
                end
            end else if (sample_now) begin
                rx_shift <= rx_next;
                if (wrap) begin
                    bit_cnt  <= '0;
                    rx_data  <= rx_next;
                    rx_valid <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    assign busy     = (state == ACTIVE);
    assign tx_ready = !hold_full;
    assign somi_oe  = !cs_cur;
    assign SOMI     = somi_oe && ((CPHA != 0) ? somi_bit : tx_out_bit);

endmodule

// File: tb/tb_spi_slave_param.sv
// tb/tb_spi_slave_param.sv - self-checking bench for spi_slave_param across widths and modes
module tb_spi_slave_param;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst, sck, simo;
    logic [5:0]  cs, tx_load;
    logic [15:0] tx_data;

    logic [5:0]  somi_w, oe_w, rdy_w, rv_w, busy_w, ur_w, fe_w;
    logic [7:0]  rxd8 [2];
    logic [15:0] rxd16 [4];

    always #5 clk = ~clk;

    // sel 0: 8-bit mode 0 MSB first; sel 1: 8-bit mode 0 LSB first, 3 sync stages
    spi_slave_param #(.DATA_W(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2)) u8m (
        .clk(clk), .rst(rst), .SCK(sck), .SIMO(simo), .CS(cs[0]), .SOMI(somi_w[0]),
        .somi_oe(oe_w[0]), .tx_data(tx_data[7:0]), .tx_load(tx_load[0]), .tx_ready(rdy_w[0]),
        .rx_data(rxd8[0]), .rx_valid(rv_w[0]), .busy(busy_w[0]), .tx_underrun(ur_w[0]),
        .frame_err(fe_w[0]));

    spi_slave_param #(.DATA_W(8), .CPOL(0), .CPHA(0), .MSB_FIRST(0), .SYNC_STAGES(3)) u8l (
        .clk(clk), .rst(rst), .SCK(sck), .SIMO(simo), .CS(cs[1]), .SOMI(somi_w[1]),
        .somi_oe(oe_w[1]), .tx_data(tx_data[7:0]), .tx_load(tx_load[1]), .tx_ready(rdy_w[1]),
        .rx_data(rxd8[1]), .rx_valid(rv_w[1]), .busy(busy_w[1]), .tx_underrun(ur_w[1]),
        .frame_err(fe_w[1]));

    // sel 2..5: 16-bit, CPOL = g/2, CPHA = g%2
    for (genvar g = 0; g < 4; g++) begin : g16
        spi_slave_param #(.DATA_W(16), .CPOL(g / 2), .CPHA(g % 2), .MSB_FIRST(1), .SYNC_STAGES(2)) u (
            .clk(clk), .rst(rst), .SCK(sck), .SIMO(simo), .CS(cs[g+2]), .SOMI(somi_w[g+2]),
            .somi_oe(oe_w[g+2]), .tx_data(tx_data), .tx_load(tx_load[g+2]), .tx_ready(rdy_w[g+2]),
            .rx_data(rxd16[g]), .rx_valid(rv_w[g+2]), .busy(busy_w[g+2]), .tx_underrun(ur_w[g+2]),
            .frame_err(fe_w[g+2]));
    end

    int   sel = 0;
    int   w = 8;
    logic cpol_b = 1'b0, cpha_b = 1'b0, msb_b = 1'b1;

    logic        m_somi, m_oe, m_rdy, m_rv, m_busy, m_ur, m_fe;
    logic [15:0] m_rxd;

    always_comb begin
        m_somi = somi_w[sel];
        m_oe   = oe_w[sel];
        m_rdy  = rdy_w[sel];
        m_rv   = rv_w[sel];
        m_busy = busy_w[sel];
        m_ur   = ur_w[sel];
        m_fe   = fe_w[sel];
        case (sel)
            0:       m_rxd = {8'h00, rxd8[0]};
            1:       m_rxd = {8'h00, rxd8[1]};
            2:       m_rxd = rxd16[0];
            3:       m_rxd = rxd16[1];
            4:       m_rxd = rxd16[2];
            default: m_rxd = rxd16[3];
        endcase
    end

    int          n_rv = 0, n_ur = 0, n_fe = 0;
    logic [15:0] rxq[$];

    always @(negedge clk) begin
        if (m_rv) begin
            n_rv <= n_rv + 1;
            rxq.push_back(m_rxd);
        end
        if (m_ur) n_ur <= n_ur + 1;
        if (m_fe) n_fe <= n_fe + 1;
    end

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_sel(input int s);
        sel    = s;
        w      = (s < 2) ? 8 : 16;
        cpol_b = (s >= 4);
        cpha_b = (s == 3) || (s == 5);
        msb_b  = (s != 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cs = '1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v);
        tx_data = v;
        tx_load[sel] = 1'b1;
        @(negedge clk);
        tx_load = '0;
        tx_data = '0;
    endtask

    task automatic wait_h(input bit ld, input logic [15:0] v);
        if (ld) begin
            do_load(v);
            repeat (H - 1) @(negedge clk);
        end else begin
            repeat (H) @(negedge clk);
        end
    endtask

    // Master side: m_tx words are sent, m_rd collects what the slave drove, ld_val[j] is offered mid-word j-1
    logic [15:0] m_tx[4], m_rd[4], ld_val[5];
    bit          ld_ok[5];
    logic        first_bit;

    task automatic frame(input int n, input int abort_bits);
        int          idx;
        bit          ld, stop;
        logic [15:0] rd;
        stop = 0;
        sck  = cpol_b;
        simo = 1'b0;
        if (ld_ok[0]) do_load(ld_val[0]);
        repeat (4) @(negedge clk);
        cs[sel] = 1'b0;
        repeat (8) @(negedge clk);
        for (int j = 0; j < n && !stop; j++) begin
            rd = '0;
            for (int i = 0; i < w; i++) begin
                if (abort_bits > 0 && j == 0 && i == abort_bits) begin
                    stop = 1;
                    break;
                end
                idx = msb_b ? (w - 1 - i) : i;
                ld  = (i == w / 2) && ld_ok[j+1];
                if (!cpha_b) begin
                    simo = m_tx[j][idx];
                    wait_h(0, '0);
                    rd[idx] = m_somi;
                    sck = ~cpol_b;
                    wait_h(ld, ld_val[j+1]);
                    sck = cpol_b;
                end else begin
                    sck = ~cpol_b;
                    simo = m_tx[j][idx];
                    wait_h(0, '0);
                    rd[idx] = m_somi;
                    sck = cpol_b;
                    wait_h(ld, ld_val[j+1]);
                end
                if (j == 0 && i == 0) first_bit = rd[idx];
            end
            m_rd[j] = rd;
        end
        wait_h(0, '0);
        cs[sel] = 1'b1;
        simo = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // Reference: master reads the offered word or zero when nothing was offered in time;
    // one underrun per word start (including the wrap after the last word) with nothing offered
    task automatic run_model(input int n, input string tag);
        int ur0, rv0, fe0, q0, exp_ur;
        ur0 = n_ur; rv0 = n_rv; fe0 = n_fe; q0 = rxq.size();
        frame(n, 0);
        exp_ur = 0;
        for (int j = 0; j <= n; j++) if (!ld_ok[j]) exp_ur++;
        for (int j = 0; j < n; j++)
            chk($sformatf("%s_read%0d", tag, j), m_rd[j], ld_ok[j] ? ld_val[j] : 16'h0000);
        chk({tag, "_rx_valid_count"}, n_rv - rv0, n);
        if (rxq.size() == q0 + n)
            for (int j = 0; j < n; j++)
                chk($sformatf("%s_rx%0d", tag, j), rxq[q0+j], m_tx[j]);
        chk({tag, "_underrun_count"}, n_ur - ur0, exp_ur);
        chk({tag, "_frame_err_count"}, n_fe - fe0, 0);
    endtask

    typedef struct {
        int          s;
        logic [15:0] tx;
        logic [15:0] mo;
        logic [15:0] exp_rd;
        logic [15:0] exp_rx;
        logic        exp_first;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int rv0, fe0, ur0, n;
        tbl[0] = '{0, 16'h00A5, 16'h003C, 16'h00A5, 16'h003C, 1'b1};
        tbl[1] = '{2, 16'h1234, 16'hBEEF, 16'h1234, 16'hBEEF, 1'b0};
        tbl[2] = '{3, 16'h1234, 16'hBEEF, 16'h1234, 16'hBEEF, 1'b0};
        tbl[3] = '{4, 16'h1234, 16'hBEEF, 16'h1234, 16'hBEEF, 1'b0};
        tbl[4] = '{5, 16'h1234, 16'hBEEF, 16'h1234, 16'hBEEF, 1'b0};
        tbl[5] = '{1, 16'h0001, 16'h0096, 16'h0001, 16'h0096, 1'b1};

        rst = 1'b1; cs = '1; sck = 1'b0; simo = 1'b0; tx_load = '0; tx_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 6; s += 5) begin
            set_sel(s);
            #1;
            chk($sformatf("reset%0d_outs", s),
                {m_somi, m_oe, m_rdy, m_rv, m_busy, m_ur, m_fe}, 7'b0010000);
            chk($sformatf("reset%0d_rx_data", s), m_rxd, 16'h0000);
        end

        // Table of single-word frames over every width/mode/bit order
        foreach (tbl[k]) begin
            do_reset();
            set_sel(tbl[k].s);
            m_tx[0] = tbl[k].mo;
            ld_ok[0] = 1; ld_val[0] = tbl[k].tx;
            ld_ok[1] = 1; ld_val[1] = 16'h0055;
            rv0 = n_rv; ur0 = n_ur; fe0 = n_fe;
            frame(1, 0);
            chk($sformatf("vec%0d_read", k), m_rd[0], tbl[k].exp_rd);
            chk($sformatf("vec%0d_rx_data", k), m_rxd, tbl[k].exp_rx);
            chk($sformatf("vec%0d_first_bit", k), first_bit, tbl[k].exp_first);
            chk($sformatf("vec%0d_rx_valid", k), n_rv - rv0, 1);
            chk($sformatf("vec%0d_underrun", k), n_ur - ur0, 0);
            chk($sformatf("vec%0d_frame_err", k), n_fe - fe0, 0);
        end

        // Burst of three words, holding register refilled each word
        do_reset(); set_sel(0);
        m_tx[0] = 16'h01; m_tx[1] = 16'h02; m_tx[2] = 16'h03;
        ld_ok[0] = 1; ld_ok[1] = 1; ld_ok[2] = 1; ld_ok[3] = 1;
        ld_val[0] = 16'h11; ld_val[1] = 16'h22; ld_val[2] = 16'h33; ld_val[3] = 16'h44;
        run_model(3, "burst");

        // Second word of a burst starts with the holding register empty
        do_reset(); set_sel(0);
        m_tx[0] = 16'h81; m_tx[1] = 16'h42;
        ld_ok[0] = 1; ld_ok[1] = 0; ld_ok[2] = 1;
        ld_val[0] = 16'h9C; ld_val[1] = 16'h00; ld_val[2] = 16'h77;
        run_model(2, "underrun");

        // Handshake: a second tx_load while the register is full is ignored
        do_reset(); set_sel(0);
        do_load(16'hAA);
        chk("hs_tx_ready_low", m_rdy, 1'b0);
        do_load(16'h55);
        m_tx[0] = 16'h0F;
        ld_ok[0] = 0; ld_ok[1] = 1; ld_val[1] = 16'h00;
        ur0 = n_ur;
        frame(1, 0);
        chk("hs_read", m_rd[0], 16'h00AA);
        chk("hs_underrun", n_ur - ur0, 0);

        // Randomised bursts over every instance
        for (int it = 0; it < 8; it++) begin
            do_reset();
            set_sel($urandom_range(0, 5));
            n = $urandom_range(1, 3);
            for (int j = 0; j <= n; j++) begin
                ld_ok[j]  = ($urandom_range(0, 3) != 0);
                ld_val[j] = 16'($urandom_range(0, (1 << w) - 1));
                if (j < n) m_tx[j] = 16'($urandom_range(0, (1 << w) - 1));
            end
            run_model(n, $sformatf("rand%0d", it));
        end

        // CS raised after 5 of 8 bits, then a clean frame
        do_reset(); set_sel(0);
        m_tx[0] = 16'h5A; ld_ok[0] = 1; ld_val[0] = 16'h00; ld_ok[1] = 1; ld_val[1] = 16'h00;
        frame(1, 0);
        chk("ferr_pre_rx_data", m_rxd, 16'h005A);
        rv0 = n_rv; fe0 = n_fe;
        m_tx[0] = 16'hFF; ld_ok[0] = 0; ld_ok[1] = 0;
        frame(1, 5);
        chk("ferr_pulses", n_fe - fe0, 1);
        chk("ferr_no_rx_valid", n_rv - rv0, 0);
        chk("ferr_rx_data_kept", m_rxd, 16'h005A);
        rv0 = n_rv; fe0 = n_fe;
        m_tx[0] = 16'hC3;
        frame(1, 0);
        chk("ferr_next_rx_data", m_rxd, 16'h00C3);
        chk("ferr_next_rx_valid", n_rv - rv0, 1);
        chk("ferr_next_no_err", n_fe - fe0, 0);

        // Reset in the middle of a frame
        do_load(16'hFF);
        sck = 1'b0; simo = 1'b1;
        cs[0] = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sck = 1'b1; repeat (H) @(negedge clk);
            sck = 1'b0; repeat (H) @(negedge clk);
        end
        chk("midrst_busy_before", m_busy, 1'b1);
        fe0 = n_fe;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_outs", {m_somi, m_oe, m_rdy, m_rv, m_busy, m_ur, m_fe}, 7'b0010000);
        chk("midrst_rx_data", m_rxd, 16'h0000);
        rst = 1'b0;
        cs[0] = 1'b1; simo = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst_no_frame_err", n_fe - fe0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
